// File: rtl/seg7_decoder.sv
// Decodes a 7-segment bus back to a digit after a stability filter; results go out
// through a one-entry valid/ready buffer. Latency: STABLE_CYCLES edges to settle, +1 to out_valid.
module seg7_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           seg_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_val,
  output logic                 out_dash,
  output logic                 out_err,
  output logic                 blank,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 overrun
);

  localparam logic [3:0] SC = 4'(STABLE_CYCLES);

  logic [6:0]           r_seg_q;
  logic [3:0]           r_cnt;
  logic                 r_valid;
  logic [3:0]           r_val;
  logic                 r_dash;
  logic                 r_err;
  logic                 r_blank;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic                 r_overrun;

  logic       w_is_digit;
  logic [3:0] w_digit;
  logic       w_is_dash;
  logic       w_is_blank;
  logic       w_is_inv;
  logic       w_evt;
  logic       w_push;
  logic       w_xfer;

  // Segment order a..g maps to bits 6..0.
  always_comb begin
    w_is_digit = 1'b1;
    w_digit    = 4'd0;
    case (seg_in)
      7'b1111110: w_digit = 4'd0;
      7'b0110000: w_digit = 4'd1;
      7'b1101101: w_digit = 4'd2;
      7'b1111001: w_digit = 4'd3;
      7'b0110011: w_digit = 4'd4;
      7'b1011011: w_digit = 4'd5;
      7'b1011111: w_digit = 4'd6;
      7'b1110000: w_digit = 4'd7;
      7'b1111111: w_digit = 4'd8;
      7'b1111011: w_digit = 4'd9;
      default:    w_is_digit = 1'b0;
    endcase
  end

  assign w_is_dash  = (seg_in == 7'b0000001);
  assign w_is_blank = (seg_in == 7'b0000000);
  assign w_is_inv   = !w_is_digit && !w_is_dash && !w_is_blank;

  // The count saturates at SC, so this edge is seen only once per stable run.
  assign w_evt  = (seg_in == r_seg_q) && (r_cnt == SC - 4'd1);
  assign w_push = w_evt && !w_is_blank;
  assign w_xfer = r_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg_q     <= 7'd0;
      r_cnt       <= 4'd0;
      r_valid     <= 1'b0;
      r_val       <= 4'd0;
      r_dash      <= 1'b0;
      r_err       <= 1'b0;
      r_blank     <= 1'b0;
      r_err_count <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_seg_q <= seg_in;
      if (seg_in != r_seg_q)
        r_cnt <= 4'd1;
      else if (r_cnt != SC)
        r_cnt <= r_cnt + 4'd1;

      if (w_evt)
        r_blank <= w_is_blank;

      if (w_evt && w_is_inv && (r_err_count != '1))
        r_err_count <= r_err_count + ERR_CNT_W'(1);

      if (w_push) begin
        if (!r_valid || out_ready) begin
          r_valid <= 1'b1;
          r_val   <= w_is_digit ? w_digit : 4'd0;
          r_dash  <= w_is_dash;
          r_err   <= w_is_inv;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_val   = r_val;
  assign out_dash  = r_dash;
  assign out_err   = r_err;
  assign blank     = r_blank;
  assign err_count = r_err_count;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed bench for seg7_decoder with STABLE_CYCLES=4, ERR_CNT_W=8.
module tb_seg7_decoder;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_val;
  logic       out_dash;
  logic       out_err;
  logic       blank;
  logic [7:0] err_count;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  seg7_decoder #(.STABLE_CYCLES(4), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_dash  (out_dash),
    .out_err   (out_err),
    .blank     (blank),
    .err_count (err_count),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs n cycles; records number of cycles with out_valid, first such cycle, last payload.
  task automatic run(input int n, output int nv, output int first,
                     output logic [3:0] v, output logic d, output logic e);
    nv = 0; first = 0; v = 4'd0; d = 1'b0; e = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        nv++;
        if (first == 0) first = i;
        v = out_val; d = out_dash; e = out_err;
      end
    end
  endtask

  initial begin
    int         nv;
    int         first;
    logic [3:0] v;
    logic       d;
    logic       e;

    rst_n = 1'b0; seg_in = 7'b0000000; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid",   32'(out_valid), 32'd0);
    chk("rst_val",     32'(out_val),   32'd0);
    chk("rst_dash",    32'(out_dash),  32'd0);
    chk("rst_err",     32'(out_err),   32'd0);
    chk("rst_blank",   32'(blank),     32'd0);
    chk("rst_errcnt",  32'(err_count), 32'd0);
    chk("rst_overrun", 32'(overrun),   32'd0);

    // Blank settles at the 4th edge after release.
    rst_n = 1'b1;
    run(3, nv, first, v, d, e);
    chk("blank_early", 32'(blank), 32'd0);
    run(1, nv, first, v, d, e);
    chk("blank_set",   32'(blank), 32'd1);
    run(6, nv, first, v, d, e);
    chk("blank_novalid", 32'(nv), 32'd0);
    chk("blank_errcnt",  32'(err_count), 32'd0);

    // Digit 3 held 10 cycles: one result, visible after the 4th edge.
    seg_in = 7'b1111001; out_ready = 1'b1;
    run(10, nv, first, v, d, e);
    chk("d3_count", 32'(nv), 32'd1);
    chk("d3_first", 32'(first), 32'd4);
    chk("d3_val",   32'(v), 32'd3);
    chk("d3_dash",  32'(d), 32'd0);
    chk("d3_err",   32'(e), 32'd0);
    chk("d3_blank", 32'(blank), 32'd0);

    // Short glitch of 5 is ignored; the following 1 settles.
    seg_in = 7'b1011011;
    run(2, nv, first, v, d, e);
    chk("glitch_none", 32'(nv), 32'd0);
    seg_in = 7'b0110000;
    run(6, nv, first, v, d, e);
    chk("d1_count", 32'(nv), 32'd1);
    chk("d1_first", 32'(first), 32'd4);
    chk("d1_val",   32'(v), 32'd1);

    // Dash, then an invalid pattern, then blank again.
    seg_in = 7'b0000001;
    run(6, nv, first, v, d, e);
    chk("dash_count", 32'(nv), 32'd1);
    chk("dash_flag",  32'(d), 32'd1);
    chk("dash_val",   32'(v), 32'd0);
    chk("dash_err",   32'(e), 32'd0);
    seg_in = 7'b1010101;
    run(6, nv, first, v, d, e);
    chk("inv_count",  32'(nv), 32'd1);
    chk("inv_err",    32'(e), 32'd1);
    chk("inv_val",    32'(v), 32'd0);
    chk("inv_dash",   32'(d), 32'd0);
    chk("inv_errcnt", 32'(err_count), 32'd1);
    chk("inv_blank",  32'(blank), 32'd0);
    seg_in = 7'b0000000;
    run(6, nv, first, v, d, e);
    chk("blank2_none", 32'(nv), 32'd0);
    chk("blank2_set",  32'(blank), 32'd1);

    // Full buffer with consumer stalled: 8 is dropped, 7 held, overrun sticks.
    out_ready = 1'b0;
    seg_in = 7'b1110000;
    run(6, nv, first, v, d, e);
    chk("ovr_valid7", 32'(out_valid), 32'd1);
    chk("ovr_val7",   32'(out_val), 32'd7);
    chk("ovr_pre",    32'(overrun), 32'd0);
    seg_in = 7'b1111111;
    run(6, nv, first, v, d, e);
    chk("ovr_hold_valid", 32'(out_valid), 32'd1);
    chk("ovr_hold_val",   32'(out_val), 32'd7);
    chk("ovr_flag",       32'(overrun), 32'd1);
    out_ready = 1'b1;
    run(1, nv, first, v, d, e);
    chk("ovr_drain", 32'(out_valid), 32'd0);
    run(10, nv, first, v, d, e);
    chk("ovr_no_repeat", 32'(nv), 32'd0);

    // Alternating invalid patterns drive the counter to saturation.
    for (int k = 0; k < 300; k++) begin
      seg_in = (k % 2 == 1) ? 7'b0101010 : 7'b1010101;
      run(4, nv, first, v, d, e);
    end
    chk("sat_errcnt",  32'(err_count), 32'd255);
    chk("sat_overrun", 32'(overrun), 32'd1);

    // One-cycle reset in the middle of a run.
    seg_in = 7'b1010101;
    run(2, nv, first, v, d, e);
    rst_n = 1'b0;
    run(1, nv, first, v, d, e);
    rst_n = 1'b1;
    chk("mid_valid",   32'(out_valid), 32'd0);
    chk("mid_errcnt",  32'(err_count), 32'd0);
    chk("mid_overrun", 32'(overrun), 32'd0);
    chk("mid_blank",   32'(blank), 32'd0);
    chk("mid_err",     32'(out_err), 32'd0);
    run(4, nv, first, v, d, e);
    chk("post_count",  32'(nv), 32'd1);
    chk("post_err",    32'(e), 32'd1);
    chk("post_errcnt", 32'(err_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_decoder.md
Name: seg7_decoder

Overview:
- Receive-side counterpart of the team's hex-to-7-segment encoder. Converts a 7-segment pattern bus back into a digit value.
- Samples seg_in every clock and rejects glitches with a stability filter. Classifies each settled pattern as digit, dash, blank or invalid.
- Hands results to a consumer through a one-entry valid/ready buffer.
- Used on loopback/self-test paths and to monitor segment buses driven by other blocks.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples needed before a pattern counts as settled (legal range 2..15).
- ERR_CNT_W, 8, width of the saturating invalid-pattern counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- seg_in  input  7  segment pattern; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g; 1 = segment lit
- out_valid  output  1  buffered result available
- out_ready  input  1  consumer accepts the result
- out_val  output  4  decoded digit 0..9; 0 for dash and invalid results
- out_dash  output  1  result is the dash pattern 7'b0000001
- out_err  output  1  result was an unrecognised pattern
- blank  output  1  last settled pattern was 7'b0000000
- err_count  output  ERR_CNT_W  saturating count of invalid settled patterns
- overrun  output  1  sticky: a result was dropped because the buffer was full

Behaviour:
- Reset:
  - Applies at a clk edge when rst_n=0 and takes priority over every other action.
  - seg_q=0, cnt=0; all outputs 0; buffer empty.
- Sample stage at each edge: seg_q<=seg_in.
- Counter update at the same edge:
  - If seg_in!=seg_q, cnt<=1.
  - Otherwise cnt<=min(cnt+1, STABLE_CYCLES).
- Settle event:
  - Fires at the edge where cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES.
  - Fires exactly once per stable run. A pattern held indefinitely produces one event.
  - Any change to seg_in restarts the run.
- Latency:
  - Pattern P first sampled at edge t and held through edge t+STABLE_CYCLES-1.
  - The event fires at edge t+STABLE_CYCLES-1.
  - out_valid is high from the following cycle.
  - After reset with seg_in=0, cnt counts from 0, so the blank event fires at edge STABLE_CYCLES after reset release.
- Classification of P at a settle event:
  - 0:1111110, 1:0110000, 2:1101101, 3:1111001, 4:0110011, 5:1011011, 6:1011111, 7:1110000, 8:1111111, 9:1111011 → digit result; out_val=digit, dash=0, err=0.
  - 0000001 → dash result; out_val=0, dash=1.
  - 0000000 → no result pushed; blank<=1.
  - Anything else → invalid result; out_val=0, err=1; err_count increments and saturates at all-ones.
  - Every non-blank event sets blank<=0.
  - err_count counts invalid events even when the result is dropped.
- Buffer / handshake:
  - A transfer occurs on any edge with out_valid && out_ready.
  - Buffer empty at an event: load the result, out_valid<=1.
  - Buffer full, out_ready=1 at the event edge: the transfer completes and the new result loads in the same edge; out_valid stays 1.
  - Buffer full, out_ready=0 at the event edge: the new result is dropped, the old one is held and overrun<=1.
  - overrun clears only on reset.
  - Transfer with no event: out_valid<=0. out_val/out_dash/out_err hold their values but are don't-care while out_valid=0.
  - While out_valid=1 and there is no transfer, out_val/out_dash/out_err are stable.
- Reset mid-run: the partial count is discarded, any buffered result is lost and err_count clears.

Test Plan:
- Reset, then seg_in=7'b0000000 constant → blank=1 after 4 edges, out_valid never rises, err_count=0.
- seg_in=7'b1111001 held 10 cycles, out_ready=1 → exactly one out_valid cycle with out_val=3 and dash=0, err=0, 4 cycles after first sample.
- seg_in=7'b1011011 for 2 cycles, then 7'b0110000 for 6 cycles → no result for 5; one result out_val=1.
- seg_in=7'b0000001 settled, then 7'b1010101 settled, out_ready=1 → dash result, then err result; err_count=1; blank=0.
- out_ready=0; settle 7 (1110000), then 8 (1111111) → out_val stays 7, overrun=1. Raise out_ready → 7 transfers, out_valid drops. Settling the same pattern again produces nothing without a change.
- 300 alternating settled invalid patterns with ERR_CNT_W=8 → err_count saturates at 255. Assert rst_n=0 for one cycle mid-run → all outputs 0 and the count restarts.
